muxn_skid_reg: RTL and testbench

- Parametrised N-input, WIDTH-bit selector with a registered output stage and a 2-entry skid buffer on a valid/ready handshake.
- Replaces fixed 32-bit 4:1 combinational selectors at pipeline stage boundaries, such as writeback-source and forwarding selects, where backpressure must be absorbed without a combinational ready path.
- Flags out-of-range selects and counts them.

---
 rtl/muxn_skid_reg_if.sv | 32 +++
 rtl/muxn_skid_reg.sv | 144 ++++++++++++++
 tb/tb_muxn_skid_reg.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/muxn_skid_reg_if.sv
// Handshake bundle for muxn_skid_reg: packed input words, select, the
// valid/ready pair on both sides, flush and the select-error reporting.
interface muxn_skid_reg_if #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 4,
    parameter int CNT_W      = 8
);
    localparam int SEL_W = $clog2(NUM_INPUTS);

    logic [NUM_INPUTS*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]            select;
    logic                        in_valid;
    logic                        in_ready;
    logic                        flush;
    logic [WIDTH-1:0]            out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_sel_err;
    logic [CNT_W-1:0]            err_count;

    // Producer/consumer side that drives the block.
    modport master (
        output in_data, select, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid, out_sel_err, err_count
    );

    // The selector block itself.
    modport slave (
        input  in_data, select, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid, out_sel_err, err_count
    );
endinterface

// File: rtl/muxn_skid_reg.sv
// N-input WIDTH-bit selector with a registered output and a 2-entry skid
// buffer. in_ready is a register, so there is no combinational path from
// out_ready back to in_ready. Out-of-range selects yield DEFAULT_VAL with an
// error flag and bump a saturating counter.
module muxn_skid_reg #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_INPUTS  = 4,
    parameter int               SEL_W       = $clog2(NUM_INPUTS),
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
    parameter int               CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    muxn_skid_reg_if.slave     bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] main_data_reg, main_data_next;
    logic             main_err_reg, main_err_next;
    logic [WIDTH-1:0] skid_data_reg, skid_data_next;
    logic             skid_err_reg, skid_err_next;
    logic             in_ready_reg, in_ready_next;
    logic [CNT_W-1:0] err_count_reg, err_count_next;

    logic [WIDTH-1:0] in_words [NUM_INPUTS];
    logic [WIDTH-1:0] cap_data;
    logic             cap_err;
    logic             accept;
    logic             pop;
    logic             out_valid;

    // Unpack the flat input bus into one word per input.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
            assign in_words[gi] = bus.in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Select the captured word; a select with no matching input falls
    // through to DEFAULT_VAL and raises the error flag. With a power-of-2
    // input count every select matches, so the flag is constant 0.
    always_comb begin
        cap_data = DEFAULT_VAL;
        cap_err  = 1'b1;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (bus.select == SEL_W'(k)) begin
                cap_data = in_words[k];
                cap_err  = 1'b0;
            end
        end
    end

    assign out_valid = (state_reg != ST_EMPTY);
    assign accept    = bus.in_valid & in_ready_reg;
    assign pop       = out_valid & bus.out_ready;

    // Occupancy next-state and entry updates; flush empties both entries
    // but leaves the main data register holding its last value.
    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        main_err_next  = main_err_reg;
        skid_data_next = skid_data_reg;
        skid_err_next  = skid_err_reg;
        err_count_next = err_count_reg;

        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next     = ST_MAIN;
                    main_data_next = cap_data;
                    main_err_next  = cap_err;
                end
            end
            ST_MAIN: begin
                if (pop && accept) begin
                    main_data_next = cap_data;
                    main_err_next  = cap_err;
                end else if (pop) begin
                    state_next = ST_EMPTY;
                end else if (accept) begin
                    state_next     = ST_FULL;
                    skid_data_next = cap_data;
                    skid_err_next  = cap_err;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_next     = ST_MAIN;
                    main_data_next = skid_data_reg;
                    main_err_next  = skid_err_reg;
                end
            end
            default: state_next = ST_EMPTY;
        endcase

        if (bus.flush) begin
            state_next     = ST_EMPTY;
            main_data_next = main_data_reg;
            main_err_next  = main_err_reg;
            skid_data_next = skid_data_reg;
            skid_err_next  = skid_err_reg;
        end

        // Counted at accept, so beats later flushed still count.
        if (accept && cap_err && (err_count_reg != {CNT_W{1'b1}}))
            err_count_next = err_count_reg + CNT_W'(1);

        in_ready_next = (state_next != ST_FULL);
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_EMPTY;
            main_data_reg <= '0;
            main_err_reg  <= 1'b0;
            skid_data_reg <= '0;
            skid_err_reg  <= 1'b0;
            in_ready_reg  <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_data_reg <= main_data_next;
            main_err_reg  <= main_err_next;
            skid_data_reg <= skid_data_next;
            skid_err_reg  <= skid_err_next;
            in_ready_reg  <= in_ready_next;
            err_count_reg <= err_count_next;
        end
    end

    assign bus.out_data    = main_data_reg;
    assign bus.out_sel_err = main_err_reg;
    assign bus.out_valid   = out_valid;
    assign bus.in_ready    = in_ready_reg;
    assign bus.err_count   = err_count_reg;
endmodule

// File: tb/tb_muxn_skid_reg.sv
// Directed bench for muxn_skid_reg: a 4-input instance for streaming,
// backpressure, flush and reset, and a 3-input instance for out-of-range
// selects and counter saturation.
module tb_muxn_skid_reg;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    muxn_skid_reg_if #(.WIDTH(32), .NUM_INPUTS(4), .CNT_W(8)) bus4 ();
    muxn_skid_reg_if #(.WIDTH(32), .NUM_INPUTS(3), .CNT_W(8)) bus3 ();

    muxn_skid_reg #(.WIDTH(32), .NUM_INPUTS(4), .CNT_W(8)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    muxn_skid_reg #(.WIDTH(32), .NUM_INPUTS(3),
                    .DEFAULT_VAL(32'hDEADBEEF), .CNT_W(8)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    task automatic check_value(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("check %s ok value=0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive all four inputs of the 4-input instance with base + k.
    task automatic set_in4(input logic [31:0] base);
        for (int k = 0; k < 4; k++)
            bus4.in_data[k*32 +: 32] = base + 32'(k);
    endtask

    initial begin
        reset          = 1'b1;
        bus4.in_data   = '0;
        bus4.select    = '0;
        bus4.in_valid  = 1'b0;
        bus4.flush     = 1'b0;
        bus4.out_ready = 1'b0;
        bus3.in_data   = '0;
        bus3.select    = '0;
        bus3.in_valid  = 1'b0;
        bus3.flush     = 1'b0;
        bus3.out_ready = 1'b0;

        // Reset state, with a beat presented during reset that must be dropped.
        bus4.in_valid = 1'b1;
        tick();
        tick();
        check_value("rst_valid", 64'(bus4.out_valid), 64'd0);
        check_value("rst_data", 64'(bus4.out_data), 64'd0);
        check_value("rst_err", 64'(bus4.out_sel_err), 64'd0);
        check_value("rst_cnt", 64'(bus4.err_count), 64'd0);
        check_value("rst_ready", 64'(bus4.in_ready), 64'd0);
        bus4.in_valid = 1'b0;
        reset = 1'b0;
        tick();
        check_value("post_rst_ready", 64'(bus4.in_ready), 64'd1);
        check_value("post_rst_valid", 64'(bus4.out_valid), 64'd0);

        // Single beat: inputs 0x11..0x44, select 2.
        bus4.in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
        bus4.select    = 2'd2;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        check_value("t1_valid", 64'(bus4.out_valid), 64'd1);
        check_value("t1_data", 64'(bus4.out_data), 64'h33);
        check_value("t1_err", 64'(bus4.out_sel_err), 64'd0);
        tick();
        check_value("t1_drain", 64'(bus4.out_valid), 64'd0);

        // Streaming: 8 beats, select cycling 0..3, one per cycle.
        for (int i = 0; i < 8; i++) begin
            set_in4(32'h100 + 32'(i*16));
            bus4.select   = 2'(i % 4);
            bus4.in_valid = 1'b1;
            tick();
            check_value($sformatf("t2_data%0d", i), 64'(bus4.out_data),
                        64'h100 + 64'(i*16) + 64'(i % 4));
            check_value($sformatf("t2_valid%0d", i), 64'(bus4.out_valid), 64'd1);
            check_value($sformatf("t2_ready%0d", i), 64'(bus4.in_ready), 64'd1);
        end
        bus4.in_valid = 1'b0;
        tick();
        check_value("t2_drain", 64'(bus4.out_valid), 64'd0);

        // Backpressure: A then B with out_ready low fills both entries.
        bus4.out_ready = 1'b0;
        bus4.select    = 2'd0;
        set_in4(32'hA0);
        bus4.in_valid  = 1'b1;
        tick();
        set_in4(32'hB0);
        tick();
        bus4.in_valid = 1'b0;
        check_value("t3_full_ready", 64'(bus4.in_ready), 64'd0);
        check_value("t3_full_data", 64'(bus4.out_data), 64'hA0);
        tick();
        check_value("t3_hold_data", 64'(bus4.out_data), 64'hA0);
        check_value("t3_hold_valid", 64'(bus4.out_valid), 64'd1);
        bus4.out_ready = 1'b1;
        tick();
        check_value("t3_pop_b", 64'(bus4.out_data), 64'hB0);
        check_value("t3_ready_back", 64'(bus4.in_ready), 64'd1);
        tick();
        check_value("t3_drain", 64'(bus4.out_valid), 64'd0);

        // Flush while full (no accept possible) and flush while accepting.
        bus4.out_ready = 1'b0;
        set_in4(32'h5A0);
        bus4.in_valid  = 1'b1;
        tick();
        set_in4(32'h5B0);
        tick();
        set_in4(32'h5C0);
        bus4.flush = 1'b1;
        tick();
        bus4.flush = 1'b0;
        check_value("t5_full_flush_valid", 64'(bus4.out_valid), 64'd0);
        check_value("t5_full_flush_ready", 64'(bus4.in_ready), 64'd1);
        check_value("t5_keep_data", 64'(bus4.out_data), 64'h5A0);
        set_in4(32'h5E0);
        tick();
        check_value("t5_e_main", 64'(bus4.out_data), 64'h5E0);
        set_in4(32'h5F0);
        bus4.flush = 1'b1;
        tick();
        bus4.flush     = 1'b0;
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        check_value("t5_acc_flush_valid", 64'(bus4.out_valid), 64'd0);
        check_value("t5_acc_flush_data", 64'(bus4.out_data), 64'h5E0);
        tick();
        check_value("t5_quiet1", 64'(bus4.out_valid), 64'd0);
        tick();
        check_value("t5_quiet2", 64'(bus4.out_valid), 64'd0);
        set_in4(32'h5D0);
        bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        check_value("t5_after_data", 64'(bus4.out_data), 64'h5D0);
        check_value("t5_after_valid", 64'(bus4.out_valid), 64'd1);
        tick();

        // 3-input instance: in-range, out-of-range, flush, saturation.
        bus3.in_data   = {32'h333, 32'h222, 32'h111};
        bus3.select    = 2'd1;
        bus3.in_valid  = 1'b1;
        bus3.out_ready = 1'b1;
        tick();
        check_value("t4_inrange_data", 64'(bus3.out_data), 64'h222);
        check_value("t4_inrange_err", 64'(bus3.out_sel_err), 64'd0);
        bus3.select = 2'd3;
        tick();
        check_value("t4_oor_data", 64'(bus3.out_data), 64'hDEADBEEF);
        check_value("t4_oor_err", 64'(bus3.out_sel_err), 64'd1);
        check_value("t4_oor_cnt", 64'(bus3.err_count), 64'd1);
        bus3.in_valid = 1'b0;
        tick();
        check_value("t4_drain", 64'(bus3.out_valid), 64'd0);
        bus3.out_ready = 1'b0;
        bus3.in_valid  = 1'b1;
        bus3.flush     = 1'b1;
        tick();
        bus3.flush    = 1'b0;
        bus3.in_valid = 1'b0;
        check_value("t4_flush_valid", 64'(bus3.out_valid), 64'd0);
        check_value("t4_flush_cnt", 64'(bus3.err_count), 64'd2);
        tick();
        check_value("t4_flush_quiet", 64'(bus3.out_valid), 64'd0);
        bus3.out_ready = 1'b1;
        bus3.in_valid  = 1'b1;
        for (int j = 1; j <= 300; j++) begin
            tick();
            if (j == 252) check_value("t4_cnt254", 64'(bus3.err_count), 64'd254);
            if (j == 253) check_value("t4_cnt255", 64'(bus3.err_count), 64'd255);
        end
        bus3.in_valid = 1'b0;
        check_value("t4_sat", 64'(bus3.err_count), 64'd255);
        check_value("t4_sat_err", 64'(bus3.out_sel_err), 64'd1);
        tick();

        // Reset in the middle of a full buffer.
        bus4.out_ready = 1'b0;
        set_in4(32'h600);
        bus4.in_valid  = 1'b1;
        tick();
        set_in4(32'h610);
        tick();
        check_value("t6_full", 64'(bus4.in_ready), 64'd0);
        reset = 1'b1;
        bus4.flush = 1'b1;
        tick();
        reset         = 1'b0;
        bus4.flush    = 1'b0;
        bus4.in_valid = 1'b0;
        check_value("t6_rst_valid", 64'(bus4.out_valid), 64'd0);
        check_value("t6_rst_data", 64'(bus4.out_data), 64'd0);
        check_value("t6_rst_ready", 64'(bus4.in_ready), 64'd0);
        check_value("t6_rst_cnt3", 64'(bus3.err_count), 64'd0);
        check_value("t6_rst_err3", 64'(bus3.out_sel_err), 64'd0);
        tick();
        check_value("t6_ready_up", 64'(bus4.in_ready), 64'd1);
        check_value("t6_still_empty", 64'(bus4.out_valid), 64'd0);
        set_in4(32'h700);
        bus4.select    = 2'd3;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        check_value("t6_first_data", 64'(bus4.out_data), 64'h703);
        check_value("t6_first_valid", 64'(bus4.out_valid), 64'd1);
        tick();
        check_value("t6_drain", 64'(bus4.out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
